// File: rtl/moore_seq_detector.sv
// -----------------------------------------------------------------------------
// moore_seq_detector
//
// Moore-style serial pattern detector. The state index is the number of
// leading PATTERN bits currently matched. State PAT_LEN is the detect state.
// PATTERN[PAT_LEN-1] is the first bit expected on the wire.
//
// On every edge that enters detect, a saturating match counter increments.
// The overlap input selects how detect is left:
//   - overlap=1: the full pattern is kept as history, so matches may overlap.
//   - overlap=0: detection restarts from S0.
// cnt_clr clears the counter on any edge and wins over a same-edge increment.
// reset is synchronous and active-low.
//
// Optional feature: define MOORE_SEQ_HIST_EN to add the 'hist' output. It holds
// the last PAT_LEN sampled bits, newest in bit 0.
// -----------------------------------------------------------------------------
module moore_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8,
    localparam int                ST_W    = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic [1:0]       b_out,
    output logic [ST_W-1:0]  st,
    output logic [CNT_W-1:0] match_cnt
`ifdef MOORE_SEQ_HIST_EN
    ,
    output logic [PAT_LEN-1:0] hist
`endif
);

    localparam logic [ST_W-1:0]  DET_ST  = ST_W'(PAT_LEN);
    localparam logic [ST_W-1:0]  IDLE_ST = {ST_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Longest pattern prefix that is a suffix of (first k pattern bits, x).
    // This is only evaluated on constants, to build the transition table.
    function automatic int calc_next(input int k, input int xb);
        int pat_v;
        int str_v;
        int res;
        pat_v = int'(PATTERN);
        str_v = ((pat_v >> (PAT_LEN - k)) << 32'sd1) | xb;
        res   = 32'sd0;
        for (int len = 1; len <= PAT_LEN; len++) begin
            if ((len <= k + 32'sd1) &&
                ((str_v & ((32'sd1 << len) - 32'sd1)) == (pat_v >> (PAT_LEN - len)))) begin
                res = len;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [ST_W-1:0]    state_r;
    logic [ST_W-1:0]    nxt_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   nxt_cnt_s;
    logic [1:0]         b_out_r;
    logic [1:0]         b_out_s;
    logic               enter_det_s;
    logic [ST_W-1:0]    nxt_tbl_s [0:PAT_LEN][0:1];

    // Constant transition table: one entry per (state, input bit).
    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_tbl_k
        for (genvar x = 0; x < 2; x++) begin : g_tbl_x
            assign nxt_tbl_s[k][x] = ST_W'(calc_next(k, x));
        end
    end

    // State register: synchronous active-low reset, otherwise load the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE_ST;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // Next-state logic. Without overlap, detect behaves like S0 for the next bit.
    always_comb begin
        nxt_state_s = state_r;
        if (en) begin
            if ((state_r == DET_ST) && !overlap) begin
                nxt_state_s = nxt_tbl_s[0][a_in];
            end else begin
                nxt_state_s = nxt_tbl_s[state_r][a_in];
            end
        end else begin
            nxt_state_s = state_r;
        end
    end

    // Next count. Every entry into detect increments, including detect-to-detect.
    // The count saturates, and a clear on the same edge wins.
    always_comb begin
        nxt_cnt_s   = cnt_r;
        enter_det_s = en && (nxt_state_s == DET_ST);
        if (cnt_clr) begin
            nxt_cnt_s = {CNT_W{1'b0}};
        end else if (enter_det_s && (cnt_r != CNT_MAX)) begin
            nxt_cnt_s = cnt_r + CNT_ONE;
        end else begin
            nxt_cnt_s = cnt_r;
        end
    end

    // Match counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= nxt_cnt_s;
        end
    end

    // Output decode from the upcoming state and count.
    // This keeps the registered b_out aligned with st and match_cnt.
    always_comb begin
        b_out_s = 2'b00;
        case (nxt_state_s)
            IDLE_ST: b_out_s = 2'b00;
            DET_ST:  b_out_s = (nxt_cnt_s == CNT_MAX) ? 2'b11 : 2'b10;
            default: b_out_s = 2'b01;
        endcase
    end

    // Status code register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            b_out_r <= 2'b00;
        end else begin
            b_out_r <= b_out_s;
        end
    end

`ifdef MOORE_SEQ_HIST_EN
    logic [PAT_LEN-1:0] hist_r;

    // History shift register of sampled bits, newest in bit 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_r <= {PAT_LEN{1'b0}};
        end else if (en) begin
            hist_r <= {hist_r[PAT_LEN-2:0], a_in};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign hist = hist_r;
`endif

    assign st        = state_r;
    assign match_cnt = cnt_r;
    assign b_out     = b_out_r;

endmodule

// File: tb/tb_moore_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_detector
//
// Self-checking bench for moore_seq_detector.
// Two instances share all inputs: one with the default counter width and one
// with CNT_W=2, which exercises saturation. A string-level reference model
// checks every cycle: state = longest pattern prefix ending the bit string
// seen since the last restart.
// Directed sequences pin hand-computed values; a random phase follows.
// Optional feature macro: MOORE_SEQ_HIST_EN (also checks the 'hist' output).
// -----------------------------------------------------------------------------
module tb_moore_seq_detector;

    localparam int PAT_LEN = 4;
    localparam int PAT_I   = 32'hB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       a_in = 1'b0;
    logic       overlap = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [1:0] b_out, b_out2;
    logic [2:0] st, st2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
`ifdef MOORE_SEQ_HIST_EN
    logic [3:0] hist, hist2;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Reference model state.
    logic [7:0] m_bits  = 8'd0;
    int         m_avail = 0;
    int         m_st    = 0;
    int         m_cnt8  = 0;
    int         m_cnt2  = 0;
    logic [3:0] m_hist  = 4'd0;

    moore_seq_detector dut (
        .clk(clk), .reset(reset), .en(en), .a_in(a_in), .overlap(overlap),
        .cnt_clr(cnt_clr), .b_out(b_out), .st(st), .match_cnt(match_cnt)
`ifdef MOORE_SEQ_HIST_EN
        , .hist(hist)
`endif
    );

    moore_seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .a_in(a_in), .overlap(overlap),
        .cnt_clr(cnt_clr), .b_out(b_out2), .st(st2), .match_cnt(match_cnt2)
`ifdef MOORE_SEQ_HIST_EN
        , .hist(hist2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Longest prefix of the pattern that is also a suffix of the last 'avail' bits.
    function automatic int longest(input logic [7:0] bits, input int avail);
        for (int len = PAT_LEN; len >= 1; len--) begin
            if (len <= avail &&
                ((int'(bits) & ((1 << len) - 1)) == (PAT_I >> (PAT_LEN - len))))
                return len;
        end
        return 0;
    endfunction

    function automatic int exp_b(input int s, input int cnt, input int cmax);
        if (s == 0) return 0;
        if (s == PAT_LEN) return (cnt == cmax) ? 3 : 2;
        return 1;
    endfunction

    // Reference model update on each rising edge.
    always @(posedge clk) begin
        if (!reset) begin
            m_bits = 8'd0; m_avail = 0; m_st = 0; m_cnt8 = 0; m_cnt2 = 0; m_hist = 4'd0;
        end else begin
            if (cnt_clr) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end
            if (en) begin
                if (m_st == PAT_LEN && !overlap) m_avail = 0;
                m_bits  = {m_bits[6:0], a_in};
                m_avail = m_avail + 1;
                m_st    = longest(m_bits, m_avail);
                m_hist  = {m_hist[2:0], a_in};
                if (m_st == PAT_LEN && !cnt_clr) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3)   m_cnt2++;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("st",         32'(st),         m_st);
            check("match_cnt",  32'(match_cnt),  m_cnt8);
            check("b_out",      32'(b_out),      exp_b(m_st, m_cnt8, 255));
            check("st2",        32'(st2),        m_st);
            check("match_cnt2", 32'(match_cnt2), m_cnt2);
            check("b_out2",     32'(b_out2),     exp_b(m_st, m_cnt2, 3));
`ifdef MOORE_SEQ_HIST_EN
            check("hist",       32'(hist),       32'(m_hist));
            check("hist2",      32'(hist2),      32'(m_hist));
`endif
        end
    end

    task automatic apply(input logic e, input logic a, input logic ov,
                         input logic clr, input logic rn);
        @(negedge clk);
        #1;
        en = e; a_in = a; overlap = ov; cnt_clr = clr; reset = rn;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, overlap, 1'b0, 1'b0);
        apply(1'b1, 1'b0, overlap, 1'b0, 1'b1);
    endtask

    logic [6:0] stream = 7'b1011011;

    initial begin
        // Reset state.
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk_on = 1'b1;
        check("rst_st", 32'(st), 0);
        check("rst_b", 32'(b_out), 0);
        check("rst_cnt", 32'(match_cnt), 0);

        // Overlapping: 1,0,1,1,0,1,1 -> detect after bits 4 and 7.
        for (int i = 6; i >= 0; i--) begin
            apply(1'b1, stream[i], 1'b1, 1'b0, 1'b1);
            if (i == 3 || i == 0) begin
                after_edge();
                check("ov_st", 32'(st), 4);
                check("ov_b", 32'(b_out), 2);
            end
        end
        check("ov_cnt", 32'(match_cnt), 2);

        // Non-overlapping: detect only after bit 4, st=1 after bit 7.
        overlap = 1'b0;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            apply(1'b1, stream[i], 1'b0, 1'b0, 1'b1);
            if (i == 3) begin
                after_edge();
                check("nov_st4", 32'(st), 4);
            end
        end
        after_edge();
        check("nov_st7", 32'(st), 1);
        check("nov_cnt", 32'(match_cnt), 1);

        // Reset mid-pattern from S3, then a full match.
        do_reset();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        after_edge();
        check("s3_st", 32'(st), 3);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        after_edge();
        check("mrst_st", 32'(st), 0);
        check("mrst_b", 32'(b_out), 0);
        check("mrst_cnt", 32'(match_cnt), 0);
        for (int i = 6; i >= 3; i--) apply(1'b1, stream[i], 1'b1, 1'b0, 1'b1);
        after_edge();
        check("mrst_det", 32'(st), 4);
        check("mrst_cnt1", 32'(match_cnt), 1);

        // en=0 for 3 cycles mid-pattern with a toggling a_in.
        do_reset();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply(1'b0, i[0], 1'b1, 1'b0, 1'b1);
        after_edge();
        check("hold_st", 32'(st), 2);
        check("hold_cnt", 32'(match_cnt), 0);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        after_edge();
        check("hold_det", 32'(st), 4);
        check("hold_cnt1", 32'(match_cnt), 1);
`ifdef MOORE_SEQ_HIST_EN
        check("hist_1011", 32'(hist), 32'hB);
`endif

        // Saturation with CNT_W=2, then a clear colliding with a detection.
        do_reset();
        for (int d = 0; d < 4; d++)
            for (int i = 6; i >= 3; i--) apply(1'b1, stream[i], 1'b1, 1'b0, 1'b1);
        after_edge();
        check("sat_cnt2", 32'(match_cnt2), 3);
        check("sat_b2", 32'(b_out2), 3);
        check("sat_cnt8", 32'(match_cnt), 4);
        check("sat_b8", 32'(b_out), 2);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        after_edge();
        check("clr_st", 32'(st), 4);
        check("clr_cnt2", 32'(match_cnt2), 0);
        check("clr_cnt8", 32'(match_cnt), 0);
        check("clr_b2", 32'(b_out2), 2);

        // Randomized phase against the model.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(3) != 0),
                  1'($urandom_range(1)),
                  ($urandom_range(7) != 0) ? overlap : ~overlap,
                  ($urandom_range(31) == 0),
                  ($urandom_range(127) != 0));
        end
        after_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
